mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one Memory/LargeMemory port pair (write channel in_*, read channel out_*) between NUM_PORTS requesters, e.g. core and program loader/debug dumper.
- Uses round-robin arbitration with a single outstanding transaction.
- Every accepted request completes with exactly one resp_valid pulse.
- A watchdog aborts transactions the memory never acknowledges and flags them with resp_error.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 32'd1024, maximum BUSY cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [NUM_PORTS] x 1  request pending, held until req_ready.
- req_write  in  [NUM_PORTS] x 1  1 = write, 0 = read.
- req_addr  in  [NUM_PORTS] x 32  word address.
- req_data  in  [NUM_PORTS] x 32  write data.
- req_ready  out  [NUM_PORTS] x 1  one-cycle accept pulse.
- resp_valid  out  [NUM_PORTS] x 1  one-cycle completion pulse.
- resp_data  out  32  read data, shared and qualified by resp_valid.
- resp_error  out  1  completion was a timeout, qualified by resp_valid.
- mem_in_addr  out  32  write address.
- mem_in_data  out  32  write data.
- mem_in_valid  out  1  write request.
- mem_in_ready  in  1  write done.
- mem_out_addr  out  32  read address.
- mem_out_valid  out  1  read request.
- mem_out_data  in  32  read data, valid when mem_out_ready=1.
- mem_out_ready  in  1  read done.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready, resp_valid, mem_in_valid, mem_out_valid and resp_error are all 0.
  - resp_data, mem addresses and mem data are all 0.
  - Reset has priority over all other inputs.
- States: IDLE, BUSY_W, BUSY_R.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - req_ready[g]=1 combinationally in that cycle. All other req_ready are 0.
  - On the edge: latch addr, data and g, clear wd_cnt, and go to BUSY_W or BUSY_R according to req_write[g].
  - No req_valid means stay in IDLE.
- BUSY_W:
  - mem_in_valid=1 with the latched addr and data. mem_out_valid=0.
  - On the cycle with mem_in_ready=1, the next cycle has resp_valid[g]=1, resp_error=0 and state IDLE.
- BUSY_R:
  - mem_out_valid=1 with the latched addr.
  - On the cycle with mem_out_ready=1, mem_out_data is registered into resp_data.
  - The next cycle has resp_valid[g]=1, resp_error=0 and state IDLE.
- Memory-side signals:
  - mem_*_valid are registered: they rise the cycle after acceptance and fall the cycle after the ready.
  - mem_*_valid are never high in IDLE and never both high.
- Pointer update: rr_ptr <= (g+1) mod NUM_PORTS at every completion, including timeouts.
- Watchdog:
  - wd_cnt (32 bit) increments each BUSY cycle without ready.
  - If TIMEOUT_CYCLES != 0 and wd_cnt reaches TIMEOUT_CYCLES-1 without ready, the request is abandoned.
  - The next cycle has valid=0, state IDLE, resp_valid[g]=1, resp_error=1 and resp_data=0.
  - A ready arriving in the same cycle as expiry counts as success.
- Overlap: the IDLE cycle carrying resp_valid may also accept a new request, so peak throughput is one transaction per memory latency + 1 cycles.
- Non-granted requesters: waiting requesters see req_ready=0. Dropping req_valid before the grant is legal and leaves no side effects.
- Reset mid-transaction: returns to IDLE next edge with no resp_valid for the aborted request. Upstream must also be reset.
- Unused inputs: mem_*_ready outside the matching BUSY state are ignored.

Test Plan:
1. Port0 writes addr 0x10, data 0xDEADBEEF; mem_in_ready is asserted on the 3rd BUSY_W cycle.
   -> req_ready[0] for 1 cycle, mem_in_valid high for exactly 3 cycles with those values, then resp_valid[0] for 1 cycle with resp_error=0.
2. Port1 reads addr 0x40; memory returns 0x12345678 with mem_out_ready on the 1st BUSY_R cycle.
   -> resp_valid[1]=1 with resp_data=0x12345678 two cycles after accept.
3. After reset, both ports request simultaneously and repeatedly.
   -> grants alternate 0,1,0,1. No port is granted twice in a row while the other is waiting.
4. TIMEOUT_CYCLES=16, port0 read, memory never ready.
   -> mem_out_valid high for exactly 16 cycles, then resp_valid[0]=1, resp_error=1, resp_data=0.
   -> a following port0 write completes normally.
5. Reset asserted on the 2nd BUSY_W cycle.
   -> mem_in_valid=0 next cycle, no resp_valid, rr_ptr=0, fresh port1 request granted.
6. Back-to-back port0 reads with memory ready on the 1st BUSY cycle.
   -> a new accept every 2 cycles, coincident with the previous resp_valid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory write/read port pair between
// NUM_PORTS requesters, one outstanding transaction, with a watchdog abort.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req_valid,
    input  logic [NUM_PORTS-1:0]    req_write,
    input  logic [NUM_PORTS*32-1:0] req_addr,
    input  logic [NUM_PORTS*32-1:0] req_data,
    output logic [NUM_PORTS-1:0]    req_ready,
    output logic [NUM_PORTS-1:0]    resp_valid,
    output logic [31:0]             resp_data,
    output logic                    resp_error,
    output logic [31:0]             mem_in_addr,
    output logic [31:0]             mem_in_data,
    output logic                    mem_in_valid,
    input  logic                    mem_in_ready,
    output logic [31:0]             mem_out_addr,
    output logic                    mem_out_valid,
    input  logic [31:0]             mem_out_data,
    input  logic                    mem_out_ready
);

    localparam int unsigned DW        = 32;
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_W = 2'd1;
    localparam logic [1:0] S_BUSY_R = 2'd2;

    logic [1:0]           state_q,         state_d;
    logic [PTR_W-1:0]     rr_ptr_q,        rr_ptr_d;
    logic [PTR_W-1:0]     gnt_q,           gnt_d;
    logic [DW-1:0]        addr_q,          addr_d;
    logic [DW-1:0]        data_q,          data_d;
    logic [31:0]          wd_cnt_q,        wd_cnt_d;
    logic [NUM_PORTS-1:0] resp_valid_q,    resp_valid_d;
    logic [DW-1:0]        resp_data_q,     resp_data_d;
    logic                 resp_error_q,    resp_error_d;
    logic                 mem_in_valid_q,  mem_in_valid_d;
    logic                 mem_out_valid_q, mem_out_valid_d;

    logic                 gnt_found_c;
    logic [PTR_W-1:0]     gnt_c;
    logic                 timeout_c;
    logic [DW-1:0]        addr_arr [NUM_PORTS];
    logic [DW-1:0]        data_arr [NUM_PORTS];

    // Split the flattened request buses into per-port words
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_arr[p] = req_addr[p*DW +: DW];
        assign data_arr[p] = req_data[p*DW +: DW];
    end

    // Round-robin scan starting at rr_ptr for the first pending requester
    always_comb begin
        logic [PTR_W-1:0] cand;
        gnt_found_c = 1'b0;
        gnt_c       = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_PORTS);
            if (!gnt_found_c && req_valid[cand]) begin
                gnt_found_c = 1'b1;
                gnt_c       = cand;
            end
        end
    end

    // Accept pulse is combinational and only offered while idle
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_found_c) begin
            req_ready[gnt_c] = 1'b1;
        end
    end

    assign timeout_c = (TIMEOUT_CYCLES != 32'd0) && (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_d           = gnt_q;
        addr_d          = addr_q;
        data_d          = data_q;
        wd_cnt_d        = wd_cnt_q;
        resp_valid_d    = '0;
        resp_data_d     = resp_data_q;
        resp_error_d    = 1'b0;
        mem_in_valid_d  = mem_in_valid_q;
        mem_out_valid_d = mem_out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_found_c) begin
                    gnt_d           = gnt_c;
                    addr_d          = addr_arr[gnt_c];
                    data_d          = data_arr[gnt_c];
                    wd_cnt_d        = 32'd0;
                    state_d         = req_write[gnt_c] ? S_BUSY_W : S_BUSY_R;
                    mem_in_valid_d  = req_write[gnt_c];
                    mem_out_valid_d = !req_write[gnt_c];
                end
            end
            S_BUSY_W, S_BUSY_R: begin
                if ((state_q == S_BUSY_W && mem_in_ready) ||
                    (state_q == S_BUSY_R && mem_out_ready) || timeout_c) begin
                    // A ready coinciding with expiry wins over the abort
                    state_d               = S_IDLE;
                    mem_in_valid_d        = 1'b0;
                    mem_out_valid_d       = 1'b0;
                    resp_valid_d[gnt_q]   = 1'b1;
                    rr_ptr_d              = (gnt_q == LAST_PORT) ? '0 : gnt_q + PTR_W'(1);
                    if (state_q == S_BUSY_W && mem_in_ready) begin
                        resp_error_d = 1'b0;
                    end else if (state_q == S_BUSY_R && mem_out_ready) begin
                        resp_data_d  = mem_out_data;
                    end else begin
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d         = S_IDLE;
                mem_in_valid_d  = 1'b0;
                mem_out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= '0;
            gnt_q           <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            wd_cnt_q        <= '0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            resp_error_q    <= 1'b0;
            mem_in_valid_q  <= 1'b0;
            mem_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            gnt_q           <= gnt_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            wd_cnt_q        <= wd_cnt_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_error_q    <= resp_error_d;
            mem_in_valid_q  <= mem_in_valid_d;
            mem_out_valid_q <= mem_out_valid_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_error    = resp_error_q;
    assign mem_in_addr   = addr_q;
    assign mem_in_data   = data_q;
    assign mem_in_valid  = mem_in_valid_q;
    assign mem_out_addr  = addr_q;
    assign mem_out_valid = mem_out_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector bench for mem_port_arbiter (2 ports, 16-cycle watchdog).
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] mem_in_addr;
    logic [31:0] mem_in_data;
    logic        mem_in_valid;
    logic        mem_in_ready;
    logic [31:0] mem_out_addr;
    logic        mem_out_valid;
    logic [31:0] mem_out_data;
    logic        mem_out_ready;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .NUM_PORTS      (2),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_error    (resp_error),
        .mem_in_addr   (mem_in_addr),
        .mem_in_data   (mem_in_data),
        .mem_in_valid  (mem_in_valid),
        .mem_in_ready  (mem_in_ready),
        .mem_out_addr  (mem_out_addr),
        .mem_out_valid (mem_out_valid),
        .mem_out_data  (mem_out_data),
        .mem_out_ready (mem_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: inputs applied for the cycle and outputs expected in it
    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [1:0]  rw;
        logic [31:0] a0, d0, a1, d1;
        logic        iw, orr;
        logic [31:0] od;
        logic [1:0]  e_rdy, e_resp;
        logic        chk_rd;
        logic [31:0] e_rdata;
        logic        e_err, e_iv, e_ov;
        logic [31:0] e_addr, e_wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] rv, input logic [1:0] rw,
        input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1,
        input logic iw, input logic orr, input logic [31:0] od,
        input logic [1:0] e_rdy, input logic [1:0] e_resp, input logic chk_rd, input logic [31:0] e_rdata,
        input logic e_err, input logic e_iv, input logic e_ov, input logic [31:0] e_addr, input logic [31:0] e_wd);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rw = rw;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.iw = iw; v.orr = orr; v.od = od;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.chk_rd = chk_rd; v.e_rdata = e_rdata;
        v.e_err = e_err; v.e_iv = e_iv; v.e_ov = e_ov; v.e_addr = e_addr; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset         = v.rst;
        req_valid     = v.rv;
        req_write     = v.rw;
        req_addr      = {v.a1, v.a0};
        req_data      = {v.d1, v.d0};
        mem_in_ready  = v.iw;
        mem_out_ready = v.orr;
        mem_out_data  = v.od;
        #1;
        chk({tag, ".req_ready"},     32'(req_ready),     32'(v.e_rdy));
        chk({tag, ".resp_valid"},    32'(resp_valid),    32'(v.e_resp));
        chk({tag, ".mem_in_valid"},  32'(mem_in_valid),  32'(v.e_iv));
        chk({tag, ".mem_out_valid"}, 32'(mem_out_valid), 32'(v.e_ov));
        if (v.e_resp != 2'b00) chk({tag, ".resp_error"}, 32'(resp_error), 32'(v.e_err));
        if (v.chk_rd)          chk({tag, ".resp_data"},  resp_data, v.e_rdata);
        if (v.e_iv) begin
            chk({tag, ".mem_in_addr"}, mem_in_addr, v.e_addr);
            chk({tag, ".mem_in_data"}, mem_in_data, v.e_wd);
        end
        if (v.e_ov) chk({tag, ".mem_out_addr"}, mem_out_addr, v.e_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
        mem_in_ready = 1'b0; mem_out_ready = 1'b0; mem_out_data = '0;
        repeat (2) @(posedge clk);

        // Reset values of the data-path registers
        @(negedge clk); #1;
        chk("reset.resp_data",    resp_data,          32'h0);
        chk("reset.resp_error",   32'(resp_error),    32'h0);
        chk("reset.mem_in_addr",  mem_in_addr,        32'h0);
        chk("reset.mem_in_data",  mem_in_data,        32'h0);
        chk("reset.mem_out_addr", mem_out_addr,       32'h0);

        // rst rv rw a0 d0 a1 d1 iw or od | rdy resp chk rdata err iv ov addr wdata
        // Port0 write, ready on 3rd BUSY_W cycle
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        // Port1 read, ready on 1st BUSY_R cycle
        vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 32'h40, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h12345678,  2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h40, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b10, 1, 32'h12345678, 0, 0, 0, 0, 0));
        // Reset, then both ports compete: grants 0,1,0,1
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h100, 32'hA0));
        vecs.push_back(mk(0, 2'b11, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 0, 0, 0,  2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h200, 32'hB1));
        vecs.push_back(mk(0, 2'b11, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 0, 0, 0,  2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h100, 32'hA0));
        vecs.push_back(mk(0, 2'b10, 2'b11, 32'h100, 32'hA0, 32'h200, 32'hB1, 0, 0, 0,  2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h200, 32'hB1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        // Port0 read so rr_ptr becomes 1
        vecs.push_back(mk(0, 2'b01, 2'b00, 32'h600, 0, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h77,  2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h600, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 1, 32'h77, 0, 0, 0, 0, 0));
        // Port1 write aborted by reset on its 2nd BUSY_W cycle; rr_ptr back to 0
        vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 32'h300, 32'hC1, 0, 0, 0,  2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h300, 32'hC1));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h300, 32'hC1));
        vecs.push_back(mk(0, 2'b11, 2'b00, 32'h700, 0, 32'h500, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 32'h700, 0, 32'h500, 0, 0, 1, 32'h55,  2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h700, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 32'h700, 0, 32'h500, 0, 0, 0, 0,  2'b10, 2'b01, 1, 32'h55, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h66,  2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h500, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b10, 1, 32'h66, 0, 0, 0, 0, 0));
        // Stray memory readies while idle are ignored
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 32'hFF,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 1, 32'h66, 0, 0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Port0 read never acknowledged: 16 valid cycles then error response
        apply(mk(0, 2'b01, 2'b00, 32'h80, 0, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0), "to.acc");
        for (int i = 0; i < 16; i++)
            apply(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h80, 0),
                  $sformatf("to.busy%0d", i));
        apply(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 1, 32'h0, 1, 0, 0, 0, 0), "to.resp");
        // Following port0 write completes normally
        apply(mk(0, 2'b01, 2'b01, 32'h84, 32'hCAFE, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0), "tw.acc");
        apply(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0,  2'b00, 2'b00, 0, 0, 0, 1, 0, 32'h84, 32'hCAFE), "tw.busy");
        apply(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0), "tw.resp");

        // Back-to-back port0 reads: accept every 2 cycles alongside previous response
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            logic [31:0] prev;
            a    = 32'h200 + 32'(k) * 32'd4;
            prev = 32'hB000_0000 + 32'(k) - 32'd1;
            apply(mk(0, 2'b01, 2'b00, a, 0, 0, 0, 0, 0, 0,  2'b01, (k != 0) ? 2'b01 : 2'b00, k != 0, prev, 0, 0, 0, 0, 0),
                  $sformatf("b2b.acc%0d", k));
            apply(mk(0, 2'b01, 2'b00, a, 0, 0, 0, 0, 1, 32'hB000_0000 + 32'(k),  2'b00, 2'b00, 0, 0, 0, 0, 1, a, 0),
                  $sformatf("b2b.busy%0d", k));
        end
        apply(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 1, 32'hB000_0003, 0, 0, 0, 0, 0), "b2b.last");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
